cva6_ptw_sv32_walker: RTL and testbench

Sv32 hardware page-table walker that sits directly downstream of the shared TLB. When the shared TLB reports an access that missed, it walks the two-level Sv32 page table through a single data-cache request port. It then returns the leaf PTE as a tlb_update_sv32_t, which refills the shared TLB; the shared TLB in turn forwards it to the ITLB/DTLB. Only one walk is in flight at a time.

---
 rtl/cva6_ptw_sv32_walker_pkg.sv | 48 ++++
 rtl/cva6_ptw_sv32_walker_pte_check.sv | 35 +++
 rtl/cva6_ptw_sv32_walker.sv | 150 +++++++++++++++
 tb/tb_cva6_ptw_sv32_walker.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cva6_ptw_sv32_walker_pkg.sv
// Shared types for the Sv32 page-table walker slice.
//   pte_sv32_t        : Sv32 page-table entry layout (32 bits)
//   tlb_update_sv32_t : refill record sent to the shared TLB
//   ptw_sv32_state_e  : walker FSM states
//   ptw_lvl_e         : page-table level currently being read
package cva6_ptw_sv32_walker_pkg;

   // Width of the asid field carried in the refill record. The walker's
   // ASID_WIDTH parameter defaults to this value and must be kept equal to it.
   localparam int unsigned SV32_ASID_WIDTH = 1;

   // A PTE is 4 bytes, so PTE addresses end in two zero bits.
   localparam int unsigned PTE_SIZE_LOG2 = 2;

   typedef struct packed {
      logic [21:0] ppn;
      logic [1:0]  rsw;
      logic        d;
      logic        a;
      logic        g;
      logic        u;
      logic        x;
      logic        w;
      logic        r;
      logic        v;
   } pte_sv32_t;

   typedef struct packed {
      logic                       valid;
      logic                       is_4M;
      logic [19:0]                vpn;
      logic [SV32_ASID_WIDTH-1:0] asid;
      pte_sv32_t                  content;
   } tlb_update_sv32_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_GRANT,
      PTE_LOOKUP,
      WAIT_RVALID
   } ptw_sv32_state_e;

   typedef enum logic {
      LVL1 = 1'b0,
      LVL0 = 1'b1
   } ptw_lvl_e;

endpackage

// File: rtl/cva6_ptw_sv32_walker_pte_check.sv
// Combinational decode of one Sv32 PTE.
//   i_pte        : PTE returned by memory
//   i_lvl1       : PTE was read at the top level (a leaf here is a 4M page)
//   o_is_leaf    : PTE maps a page (R or X set)
//   o_misaligned : 4M leaf whose low PPN bits are not zero
//   o_is_fault   : walk must end in a page fault
module cva6_ptw_sv32_walker_pte_check
   import cva6_ptw_sv32_walker_pkg::*;
(
   input  pte_sv32_t i_pte,
   input  logic      i_lvl1,
   output logic      o_is_leaf,
   output logic      o_misaligned,
   output logic      o_is_fault
);

   logic w_invalid;
   logic w_unused_bits;

   // W without R is a reserved encoding and is treated like V=0.
   assign w_invalid    = ~i_pte.v | (~i_pte.r & i_pte.w);
   assign o_is_leaf    = i_pte.r | i_pte.x;
   assign o_misaligned = o_is_leaf & i_lvl1 & (i_pte.ppn[9:0] != 10'd0);

   // A=0 faults because accessed/dirty bits are never updated in hardware;
   // a pointer at the last level has nowhere left to go.
   assign o_is_fault = w_invalid
                     | (o_is_leaf & ~i_pte.a)
                     | o_misaligned
                     | (~o_is_leaf & ~i_lvl1);

   // Fields the decode does not need.
   assign w_unused_bits = ^{i_pte.ppn[21:10], i_pte.rsw, i_pte.d, i_pte.g, i_pte.u};

endmodule

// File: rtl/cva6_ptw_sv32_walker.sv
// Sv32 page-table walker behind the shared TLB. On a shared-TLB miss it
// reads up to two PTEs through one memory port and refills the shared TLB
// with the leaf, or pulses a page fault.
//   clk_i, rst_ni                 : clock, asynchronous active-low reset
//   flush_i                       : abort any walk in progress
//   satp_ppn_i, asid_i            : root table PPN and current ASID
//   shared_tlb_*_i, itlb_req_i    : lookup result that may start a walk
//   mem_req_o/addr_o/gnt_i        : PTE read request handshake
//   mem_rvalid_i/rdata_i          : PTE read response
//   shared_tlb_update_o           : one-cycle refill record
//   ptw_active_o, walking_instr_o : walk status
//   ptw_error_o, bad_vaddr_o      : one-cycle page-fault report
module cva6_ptw_sv32_walker
   import cva6_ptw_sv32_walker_pkg::*;
#(
   parameter int unsigned ASID_WIDTH = SV32_ASID_WIDTH,
   parameter int unsigned PLEN       = 34
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic [21:0]           satp_ppn_i,
   input  logic [ASID_WIDTH-1:0] asid_i,
   input  logic                  shared_tlb_access_i,
   input  logic                  shared_tlb_hit_i,
   input  logic [31:0]           shared_tlb_vaddr_i,
   input  logic                  itlb_req_i,
   output logic                  mem_req_o,
   output logic [PLEN-1:0]       mem_addr_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_rvalid_i,
   input  logic [31:0]           mem_rdata_i,
   output tlb_update_sv32_t      shared_tlb_update_o,
   output logic                  ptw_active_o,
   output logic                  walking_instr_o,
   output logic                  ptw_error_o,
   output logic [31:0]           bad_vaddr_o
);

   ptw_sv32_state_e       r_state, w_state_next;
   ptw_lvl_e              r_level, w_level_next;
   logic [31:0]           r_vaddr;
   logic                  r_itlb;
   logic [ASID_WIDTH-1:0] r_asid;
   logic [PLEN-1:0]       r_addr, w_addr_next;
   logic                  w_latch;

   pte_sv32_t             w_pte;
   logic                  w_is_leaf, w_is_fault, w_misaligned;
   logic                  w_unused_misaligned;
   logic [33:0]           w_root_addr, w_l0_addr;

   assign w_pte = pte_sv32_t'(mem_rdata_i);

   // PTE addresses are plain concatenations: table PPN, VPN slice, byte offset.
   assign w_root_addr = {satp_ppn_i, shared_tlb_vaddr_i[31:22], {PTE_SIZE_LOG2{1'b0}}};
   assign w_l0_addr   = {w_pte.ppn, r_vaddr[21:12], {PTE_SIZE_LOG2{1'b0}}};

   cva6_ptw_sv32_walker_pte_check u_pte_check (
      .i_pte        (w_pte),
      .i_lvl1       (r_level == LVL1),
      .o_is_leaf    (w_is_leaf),
      .o_misaligned (w_misaligned),
      .o_is_fault   (w_is_fault)
   );

   // Misalignment is already folded into w_is_fault.
   assign w_unused_misaligned = w_misaligned;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_level <= LVL1;
         r_vaddr <= '0;
         r_itlb  <= 1'b0;
         r_asid  <= '0;
         r_addr  <= '0;
      end else begin
         r_state <= w_state_next;
         r_level <= w_level_next;
         r_addr  <= w_addr_next;
         if (w_latch) begin
            r_vaddr <= shared_tlb_vaddr_i;
            r_itlb  <= itlb_req_i;
            r_asid  <= asid_i;
         end
      end
   end

   always_comb begin
      w_state_next        = r_state;
      w_level_next        = r_level;
      w_addr_next         = r_addr;
      w_latch             = 1'b0;
      shared_tlb_update_o = '0;
      ptw_error_o         = 1'b0;
      bad_vaddr_o         = '0;

      unique case (r_state)
         IDLE: begin
            if (shared_tlb_access_i && !shared_tlb_hit_i && !flush_i) begin
               w_latch      = 1'b1;
               w_level_next = LVL1;
               w_addr_next  = w_root_addr[PLEN-1:0];
               w_state_next = WAIT_GRANT;
            end
         end
         WAIT_GRANT: begin
            // A granted request still owes a response, even when flushed.
            if (mem_gnt_i)    w_state_next = flush_i ? WAIT_RVALID : PTE_LOOKUP;
            else if (flush_i) w_state_next = IDLE;
         end
         PTE_LOOKUP: begin
            if (mem_rvalid_i) begin
               if (flush_i) begin
                  w_state_next = IDLE;
               end else if (w_is_fault) begin
                  ptw_error_o  = 1'b1;
                  bad_vaddr_o  = r_vaddr;
                  w_state_next = IDLE;
               end else if (w_is_leaf) begin
                  shared_tlb_update_o.valid   = 1'b1;
                  shared_tlb_update_o.is_4M   = (r_level == LVL1);
                  shared_tlb_update_o.vpn     = r_vaddr[31:12];
                  shared_tlb_update_o.asid    = r_asid;
                  shared_tlb_update_o.content = w_pte;
                  w_state_next                = IDLE;
               end else begin
                  // Pointer at the top level; non-leaf at LVL0 is a fault above.
                  w_level_next = LVL0;
                  w_addr_next  = w_l0_addr[PLEN-1:0];
                  w_state_next = WAIT_GRANT;
               end
            end else if (flush_i) begin
               w_state_next = WAIT_RVALID;
            end
         end
         WAIT_RVALID: begin
            if (mem_rvalid_i) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign mem_req_o       = (r_state == WAIT_GRANT);
   assign mem_addr_o      = r_addr;
   assign ptw_active_o    = (r_state != IDLE);
   assign walking_instr_o = ptw_active_o & r_itlb;

endmodule

// File: tb/tb_cva6_ptw_sv32_walker.sv
module tb_cva6_ptw_sv32_walker;
   import cva6_ptw_sv32_walker_pkg::*;

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b0;
   logic             flush_i = 1'b0;
   logic [21:0]      satp_ppn_i = '0;
   logic [0:0]       asid_i = '0;
   logic             shared_tlb_access_i = 1'b0;
   logic             shared_tlb_hit_i = 1'b0;
   logic [31:0]      shared_tlb_vaddr_i = '0;
   logic             itlb_req_i = 1'b0;
   logic             mem_req_o;
   logic [33:0]      mem_addr_o;
   logic             mem_gnt_i = 1'b0;
   logic             mem_rvalid_i = 1'b0;
   logic [31:0]      mem_rdata_i = '0;
   tlb_update_sv32_t shared_tlb_update_o;
   logic             ptw_active_o;
   logic             walking_instr_o;
   logic             ptw_error_o;
   logic [31:0]      bad_vaddr_o;

   int n_pass = 0;
   int n_total = 0;
   int upd_cnt = 0;
   int err_cnt = 0;

   cva6_ptw_sv32_walker #(.ASID_WIDTH(1), .PLEN(34)) dut (
      .clk_i               (clk_i),
      .rst_ni              (rst_ni),
      .flush_i             (flush_i),
      .satp_ppn_i          (satp_ppn_i),
      .asid_i              (asid_i),
      .shared_tlb_access_i (shared_tlb_access_i),
      .shared_tlb_hit_i    (shared_tlb_hit_i),
      .shared_tlb_vaddr_i  (shared_tlb_vaddr_i),
      .itlb_req_i          (itlb_req_i),
      .mem_req_o           (mem_req_o),
      .mem_addr_o          (mem_addr_o),
      .mem_gnt_i           (mem_gnt_i),
      .mem_rvalid_i        (mem_rvalid_i),
      .mem_rdata_i         (mem_rdata_i),
      .shared_tlb_update_o (shared_tlb_update_o),
      .ptw_active_o        (ptw_active_o),
      .walking_instr_o     (walking_instr_o),
      .ptw_error_o         (ptw_error_o),
      .bad_vaddr_o         (bad_vaddr_o)
   );

   always #5 clk_i = ~clk_i;

   // Count refill and fault pulses over the whole run.
   always @(posedge clk_i) begin
      if (shared_tlb_update_o.valid) upd_cnt <= upd_cnt + 1;
      if (ptw_error_o)               err_cnt <= err_cnt + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
   endtask

   // Present one miss for a single cycle; returns at the negedge after it.
   task automatic miss(input logic [31:0] va, input logic it);
      @(negedge clk_i);
      shared_tlb_access_i = 1'b1;
      shared_tlb_hit_i    = 1'b0;
      shared_tlb_vaddr_i  = va;
      itlb_req_i          = it;
      @(negedge clk_i);
      shared_tlb_access_i = 1'b0;
      itlb_req_i          = 1'b0;
   endtask

   // Check the pending request, grant it, then drive the response; returns
   // with rvalid still high so the caller can inspect the decode outputs.
   task automatic serve(input string tag, input logic [33:0] exp_addr, input logic [31:0] pte);
      #1;
      chk({tag, "_req"}, mem_req_o, 1'b1);
      chk({tag, "_addr"}, mem_addr_o, exp_addr);
      mem_gnt_i = 1'b1;
      @(negedge clk_i);
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = pte;
      #1;
   endtask

   task automatic end_rsp;
      @(negedge clk_i);
      mem_rvalid_i = 1'b0;
      #1;
   endtask

   logic [31:0] fault_ptes [4];

   initial begin
      fault_ptes[0] = 32'h00000000;   // V=0
      fault_ptes[1] = 32'h200004CF;   // misaligned 4M leaf
      fault_ptes[2] = 32'h2000008F;   // leaf with A=0
      fault_ptes[3] = 32'h00000005;   // W without R

      // Reset state
      repeat (2) @(negedge clk_i);
      #1;
      chk("rst_req", mem_req_o, 1'b0);
      chk("rst_addr", mem_addr_o, 34'h0);
      chk("rst_upd", shared_tlb_update_o, '0);
      chk("rst_active", ptw_active_o, 1'b0);
      chk("rst_instr", walking_instr_o, 1'b0);
      chk("rst_err", ptw_error_o, 1'b0);
      chk("rst_bad", bad_vaddr_o, 32'h0);
      rst_ni = 1'b1;
      satp_ppn_i = 22'h00080;

      // 4K walk: root 0x80, vpn1=0x100, vpn0=0x001; pointer ppn = 0x80
      asid_i = 1'b1;
      miss(32'h40001000, 1'b0);
      serve("l1_4k", 34'h0_0008_0400, 32'h00020001);
      chk("l1_4k_upd", shared_tlb_update_o.valid, 1'b0);
      chk("l1_4k_err", ptw_error_o, 1'b0);
      end_rsp();
      asid_i = 1'b0;
      serve("l0_4k", 34'h0_0008_0004, 32'h200000CF);
      chk("4k_valid", shared_tlb_update_o.valid, 1'b1);
      chk("4k_vpn", shared_tlb_update_o.vpn, 20'h40001);
      chk("4k_is4M", shared_tlb_update_o.is_4M, 1'b0);
      chk("4k_asid", shared_tlb_update_o.asid, 1'b1);
      chk("4k_content", shared_tlb_update_o.content, 32'h200000CF);
      chk("4k_instr", walking_instr_o, 1'b0);
      end_rsp();
      chk("4k_idle", ptw_active_o, 1'b0);
      chk("4k_upd_cnt", upd_cnt, 1);

      // 4M superpage from the ITLB, one memory access
      miss(32'h40001000, 1'b1);
      #1;
      chk("4m_instr_wg", walking_instr_o, 1'b1);
      serve("l1_4m", 34'h0_0008_0400, 32'h200000CF);
      chk("4m_valid", shared_tlb_update_o.valid, 1'b1);
      chk("4m_is4M", shared_tlb_update_o.is_4M, 1'b1);
      chk("4m_vpn", shared_tlb_update_o.vpn, 20'h40001);
      chk("4m_asid", shared_tlb_update_o.asid, 1'b0);
      chk("4m_instr", walking_instr_o, 1'b1);
      end_rsp();
      chk("4m_no_2nd_req", mem_req_o, 1'b0);
      chk("4m_idle", ptw_active_o, 1'b0);
      chk("4m_instr_off", walking_instr_o, 1'b0);
      chk("4m_upd_cnt", upd_cnt, 2);

      // Single-level faults
      for (int i = 0; i < 4; i++) begin
         miss(32'h40001000, 1'b0);
         serve($sformatf("flt%0d", i), 34'h0_0008_0400, fault_ptes[i]);
         chk($sformatf("flt%0d_err", i), ptw_error_o, 1'b1);
         chk($sformatf("flt%0d_bad", i), bad_vaddr_o, 32'h40001000);
         chk($sformatf("flt%0d_upd", i), shared_tlb_update_o.valid, 1'b0);
         end_rsp();
         chk($sformatf("flt%0d_pulse", i), ptw_error_o, 1'b0);
         chk($sformatf("flt%0d_idle", i), ptw_active_o, 1'b0);
      end

      // Pointer at LVL0 faults
      miss(32'h40001000, 1'b0);
      serve("l0flt_l1", 34'h0_0008_0400, 32'h00020001);
      end_rsp();
      serve("l0flt_l0", 34'h0_0008_0004, 32'h00000001);
      chk("l0flt_err", ptw_error_o, 1'b1);
      chk("l0flt_bad", bad_vaddr_o, 32'h40001000);
      chk("l0flt_upd", shared_tlb_update_o.valid, 1'b0);
      end_rsp();
      chk("flt_upd_cnt", upd_cnt, 2);
      chk("flt_err_cnt", err_cnt, 5);

      // Flush one cycle after grant, response three cycles later
      miss(32'h40001000, 1'b0);
      #1;
      mem_gnt_i = 1'b1;
      @(negedge clk_i);
      mem_gnt_i = 1'b0;
      flush_i   = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      #1;
      chk("fl_lk_active", ptw_active_o, 1'b1);
      chk("fl_lk_req", mem_req_o, 1'b0);
      repeat (2) @(negedge clk_i);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h200000CF;
      #1;
      chk("fl_lk_upd", shared_tlb_update_o.valid, 1'b0);
      chk("fl_lk_err", ptw_error_o, 1'b0);
      chk("fl_lk_busy", ptw_active_o, 1'b1);
      end_rsp();
      chk("fl_lk_idle", ptw_active_o, 1'b0);

      // Next miss after the flush is accepted (vpn1 = 1)
      miss(32'h00400000, 1'b0);
      serve("af", 34'h0_0008_0004, 32'h200000CF);
      chk("af_valid", shared_tlb_update_o.valid, 1'b1);
      chk("af_vpn", shared_tlb_update_o.vpn, 20'h00400);
      end_rsp();

      // Flush in WAIT_GRANT without grant
      miss(32'h40001000, 1'b0);
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      #1;
      chk("fl_wg_req", mem_req_o, 1'b0);
      chk("fl_wg_idle", ptw_active_o, 1'b0);

      // Flush together with grant: response must still be absorbed
      miss(32'h40001000, 1'b0);
      flush_i   = 1'b1;
      mem_gnt_i = 1'b1;
      @(negedge clk_i);
      flush_i   = 1'b0;
      mem_gnt_i = 1'b0;
      #1;
      chk("fl_gnt_busy", ptw_active_o, 1'b1);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h200000CF;
      #1;
      chk("fl_gnt_upd", shared_tlb_update_o.valid, 1'b0);
      end_rsp();
      chk("fl_gnt_idle", ptw_active_o, 1'b0);
      chk("fl_upd_cnt", upd_cnt, 3);
      chk("fl_err_cnt", err_cnt, 5);

      // Grant backpressure; a second miss while busy is ignored
      miss(32'h40001000, 1'b0);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("bp%0d_req", i), mem_req_o, 1'b1);
         chk($sformatf("bp%0d_addr", i), mem_addr_o, 34'h0_0008_0400);
         shared_tlb_access_i = (i == 2);
         shared_tlb_vaddr_i  = (i == 2) ? 32'h80000000 : 32'h40001000;
         @(negedge clk_i);
      end
      shared_tlb_access_i = 1'b0;
      serve("bp_done", 34'h0_0008_0400, 32'h200000CF);
      chk("bp_vpn", shared_tlb_update_o.vpn, 20'h40001);
      end_rsp();

      // Hit filter and flush-in-IDLE filter
      @(negedge clk_i);
      shared_tlb_access_i = 1'b1;
      shared_tlb_hit_i    = 1'b1;
      @(negedge clk_i);
      shared_tlb_hit_i = 1'b0;
      flush_i          = 1'b1;
      @(negedge clk_i);
      shared_tlb_access_i = 1'b0;
      flush_i             = 1'b0;
      #1;
      chk("hit_idle", ptw_active_o, 1'b0);
      chk("hit_req", mem_req_o, 1'b0);

      // Asynchronous reset mid-walk
      miss(32'h40001000, 1'b1);
      #1;
      rst_ni = 1'b0;
      #1;
      chk("arst_idle", ptw_active_o, 1'b0);
      chk("arst_req", mem_req_o, 1'b0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
